// File: rtl/call_stack_pkg.sv
// Shared definitions for the call/return stack: per-cycle operation encoding
// and the count-width helper.
package call_stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/call_stack_if.sv
// Bundle of the stack's operation inputs and status outputs; the PC logic
// drives the master side, the stack implements the slave side.
interface call_stack_if
    import call_stack_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, din, clr_err,
        input  top, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din, clr_err,
        output top, count, empty, full, ovf, unf
    );

endinterface

// File: rtl/call_stack_mem.sv
// Entry storage for the call stack: one synchronous write port, one
// asynchronous read port, no reset.
module call_stack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Out-of-range addresses occur when the caller discards the read data anyway.
    always_comb begin
        o_rdata = '0;
        if (int'(i_raddr) < DEPTH) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/call_stack.sv
// Call/return stack: op decode, saturating count, registered top-of-stack and
// sticky overflow/underflow flags around a register-array store.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    call_stack_if.slave  bus
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    op_e              w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_top;
    logic             r_ovf;
    logic             r_unf;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_op = OP_NONE;
        if (bus.push && bus.pop) begin
            w_op = OP_REPL;
        end else if (bus.push) begin
            w_op = OP_PUSH;
        end else if (bus.pop) begin
            w_op = OP_POP;
        end
    end

    // Replace overwrites the current top; a replace on an empty stack degrades to a push.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = AW'(r_count);
        if (w_op == OP_PUSH && !w_full) begin
            w_we = 1'b1;
        end else if (w_op == OP_REPL) begin
            w_we = 1'b1;
            if (!w_empty) begin
                w_waddr = AW'(r_count - CNT_W'(1));
            end
        end
    end

    assign w_raddr = AW'(r_count - CNT_W'(2));

    call_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.din),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            // Error events below override a same-cycle clear.
            if (bus.clr_err) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                        r_top   <= bus.din;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                        r_top   <= (r_count == CNT_W'(1)) ? '0 : w_rdata;
                    end
                end
                OP_REPL: begin
                    r_top <= bus.din;
                    if (w_empty) begin
                        r_count <= CNT_W'(1);
                        r_unf   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.top   = r_top;
    assign bus.count = r_count;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware call/return stack combining storage and stack-pointer tracking in one block. Holds return addresses or temporary data for the program-counter path. Provides full/empty status, an occupancy count, push-and-pop-in-one-cycle replacement, sticky overflow/underflow error flags, and a registered top-of-stack output. Sits between the PC-next logic (push source) and the PC mux (return-address consumer).

## Interface
- WIDTH, 12, entry width in bits (≥1)
- DEPTH, 4, number of entries (≥2, need not be a power of two)
- CNT_W, $clog2(DEPTH+1), derived count width; not overridden
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- push  in  1  write din as new top this cycle
- pop  in  1  remove top this cycle
- din  in  WIDTH  data to push (e.g. pcx)
- clr_err  in  1  synchronous clear of ovf/unf
- top  out  WIDTH  registered current top entry; 0 when empty
- count  out  CNT_W  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  sticky: push refused because full
- unf  out  1  sticky: pop refused because empty

## Operation
- Decode per cycle (evaluated against current count):
  - NONE: neither push nor pop → no change.
  - PUSH: push only, not full → mem[count] ← din; count+1; top ← din.
  - PUSH, full: ignored; ovf ← 1; count, mem, top unchanged.
  - POP: pop only, not empty → count−1; top ← mem[count−2], or 0 if count was 1.
  - POP, empty: ignored; unf ← 1.
  - REPL: push and pop, not empty → mem[count−1] ← din; count unchanged; top ← din. Legal when full; no ovf.
  - push and pop while empty → behaves as PUSH (count 0→1, top ← din) and unf ← 1.
- empty/full are combinational decodes of the count register.
- clr_err clears ovf and unf; an error event in the same cycle wins (flag ends at 1).
- Memory contents are not reset; entries at index ≥ count are never observable.
- No wrap-around: pointer saturates at 0 and DEPTH, unlike an index that silently wraps.

## Timing
- Reset (rst_n low, async): count=0, top=0, empty=1, full=0, ovf=0, unf=0, held until first rising clk after rst_n high.
- Reset asserted mid-operation: stack is emptied immediately; the in-flight push/pop is discarded.
- top, count, empty, full, ovf, unf all reflect an operation one cycle after the edge that samples it (latency 1); back-to-back operations every cycle are supported.
- A pop issued the cycle after a push returns the just-pushed value on top before the pop edge, and the prior entry after it.
- No combinational path from inputs to outputs.

## Structure
- Shared package call_stack_pkg: op encoding enum (OP_NONE, OP_PUSH, OP_POP, OP_REPL) and helper for CNT_W derivation.
- One sub-module: call_stack_mem — DEPTH×WIDTH register array, one synchronous write port, one asynchronous read port (address count−2 for pop look-ahead); no reset.
- Top level holds op decode, count register, top register, flags.

## Test plan
- Reset then push 0x100,0x200,0x300,0x400 on 4 consecutive cycles → count 1..4, top follows din, full=1 after 4th; ovf=0.
- From full, push 0x555 → count stays 4, top stays 0x400, ovf=1; then clr_err → ovf=0.
- From full, pop ×4 → top 0x300,0x200,0x100,0x000, count 3..0, empty=1; 5th pop → unf=1, count 0.
- Push 0xABC, then push+pop 0xDEF → count 1, top 0xDEF; pop → top 0, empty=1.
- Push+pop with stack empty and din 0x077 → count 1, top 0x077, unf=1; simultaneous clr_err same cycle → unf still 1.
- Push 0x111, 0x222, drop rst_n between edges → count 0, top 0, empty=1 immediately, no clk edge required.
